// File: rtl/uart_alu_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_frame_ctrl_pkg
// Brief    : Shared types and constants for the UART/ALU frame sequencer.
//            Used by uart_alu_frame_ctrl and frame_timeout_ctr.
//            The optional inter-byte timeout is enabled by FRAME_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
package uart_alu_frame_ctrl_pkg;

   // Sequencer states: frame parsing, check/execute, then two-byte response
   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_GET_OP   = 4'd1,
      S_GET_A    = 4'd2,
      S_GET_B    = 4'd3,
      S_GET_CHK  = 4'd4,
      S_CHECK    = 4'd5,
      S_EXEC     = 4'd6,
      S_SEND_ST  = 4'd7,
      S_WAIT_ST  = 4'd8,
      S_SEND_RES = 4'd9,
      S_WAIT_RES = 4'd10
   } state_e;

   // Response status codes
   localparam logic [7:0] ST_OK      = 8'h00;
   localparam logic [7:0] ST_CHK_ERR = 8'h01;

   // Default frame start marker
   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   // Command frame: SYNC, OP, A, B, CHK. Response frame: STATUS, RESULT.
   localparam int unsigned FRAME_LEN = 5;
   localparam int unsigned RESP_LEN  = 2;

endpackage : uart_alu_frame_ctrl_pkg
`default_nettype wire

// File: rtl/uart_alu_frame_ctrl_timeout.sv
`default_nettype none
// ============================================================================
// Module   : frame_timeout_ctr
// Brief    : Loadable cycle counter with an expire flag. Counts cycles while
//            i_run is high, restarts on i_load, and flags o_expire on the
//            LIMIT-th cycle since the last restart. Only instantiated when
//            FRAME_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module frame_timeout_ctr
   import uart_alu_frame_ctrl_pkg::*;
#(
   parameter int unsigned LIMIT = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_load,
   input  logic i_run,
   output logic o_expire
);

   localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] count_q, count_d;

   // Restart on an accepted byte or when idle, otherwise count up and park at the last value
   always_comb begin
      count_d = count_q;
      if (!i_run || i_load) begin
         count_d = '0;
      end else if (count_q != C_LAST) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_expire = i_run && (count_q == C_LAST);

endmodule : frame_timeout_ctr
`default_nettype wire

// File: rtl/uart_alu_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_frame_ctrl
// Brief    : Framed command sequencer between UART rx/tx and a combinational
//            ALU. Parses SYNC,OP,A,B,CHK, commits operands on a good checksum,
//            and answers with STATUS,RESULT through the tx handshake.
//            Optional inter-byte timeout: define FRAME_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_alu_frame_ctrl
   import uart_alu_frame_ctrl_pkg::*;
#(
   parameter int unsigned   N              = 8,
   parameter logic [N-1:0]  SYNC_BYTE      = N'(SYNC_BYTE_DEFAULT),
   parameter int unsigned   TIMEOUT_CYCLES = 1000000,
   parameter int unsigned   ERR_W          = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     i_rx_data,
   input  logic             i_rx_valid,
   input  logic             i_tx_done,
   input  logic [N-1:0]     i_alu_result,
   output logic [N-1:0]     o_A,
   output logic [N-1:0]     o_B,
   output logic [N-1:0]     o_op,
   output logic [N-1:0]     o_tx_data,
   output logic             o_tx_start,
   output logic             o_busy,
   output logic [ERR_W-1:0] o_err_cnt
);

   state_e           state_q, state_d;

   // Shadow registers hold the frame until the checksum is known good
   logic [N-1:0]     op_sh_q, op_sh_d;
   logic [N-1:0]     a_sh_q,  a_sh_d;
   logic [N-1:0]     b_sh_q,  b_sh_d;
   logic [N-1:0]     chk_q,   chk_d;

   // Committed ALU operands and response data
   logic [N-1:0]     op_q, op_d;
   logic [N-1:0]     a_q,  a_d;
   logic [N-1:0]     b_q,  b_d;
   logic [N-1:0]     result_q, result_d;
   logic [N-1:0]     tx_data_q, tx_data_d;
   logic             tx_start_q, tx_start_d;
   logic             busy_q, busy_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic             w_in_get;
   logic             w_expire;
   logic             w_err_inc;

   assign w_in_get = (state_q == S_GET_OP) || (state_q == S_GET_A) ||
                     (state_q == S_GET_B)  || (state_q == S_GET_CHK);

`ifdef FRAME_TIMEOUT_EN
   frame_timeout_ctr #(
      .LIMIT    (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .i_load   (i_rx_valid),
      .i_run    (w_in_get),
      .o_expire (w_expire)
   );
`else
   assign w_expire = 1'b0;
`endif

   // Next-state and datapath decode; outputs are registered from the next state
   always_comb begin
      state_d   = state_q;
      op_sh_d   = op_sh_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      chk_d     = chk_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      tx_data_d = tx_data_q;
      w_err_inc = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
               state_d = S_GET_OP;
            end
         end
         S_GET_OP: begin
            if (i_rx_valid) begin
               op_sh_d = i_rx_data;
               state_d = S_GET_A;
            end
         end
         S_GET_A: begin
            if (i_rx_valid) begin
               a_sh_d  = i_rx_data;
               state_d = S_GET_B;
            end
         end
         S_GET_B: begin
            if (i_rx_valid) begin
               b_sh_d  = i_rx_data;
               state_d = S_GET_CHK;
            end
         end
         S_GET_CHK: begin
            if (i_rx_valid) begin
               chk_d   = i_rx_data;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (chk_q == (op_sh_q ^ a_sh_q ^ b_sh_q)) begin
               op_d    = op_sh_q;
               a_d     = a_sh_q;
               b_d     = b_sh_q;
               state_d = S_EXEC;
            end else begin
               // Failed frame: ALU operands stay untouched
               tx_data_d = N'(ST_CHK_ERR);
               result_d  = '0;
               w_err_inc = 1'b1;
               state_d   = S_SEND_ST;
            end
         end
         S_EXEC: begin
            // Operands were committed last cycle, so the ALU output has settled
            result_d  = i_alu_result;
            tx_data_d = N'(ST_OK);
            state_d   = S_SEND_ST;
         end
         S_SEND_ST: begin
            state_d = S_WAIT_ST;
         end
         S_WAIT_ST: begin
            if (i_tx_done) begin
               tx_data_d = result_q;
               state_d   = S_SEND_RES;
            end
         end
         S_SEND_RES: begin
            state_d = S_WAIT_RES;
         end
         S_WAIT_RES: begin
            if (i_tx_done) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Inter-byte timeout; a byte on the expiry cycle takes priority
      if (w_in_get && !i_rx_valid && w_expire) begin
         state_d   = S_IDLE;
         w_err_inc = 1'b1;
      end

      tx_start_d = (state_d == S_SEND_ST) || (state_d == S_SEND_RES);
      busy_d     = (state_d != S_IDLE);
      err_cnt_d  = (w_err_inc && (err_cnt_q != {ERR_W{1'b1}})) ?
                   err_cnt_q + ERR_W'(1) : err_cnt_q;
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         op_sh_q    <= '0;
         a_sh_q     <= '0;
         b_sh_q     <= '0;
         chk_q      <= '0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         result_q   <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         op_sh_q    <= op_sh_d;
         a_sh_q     <= a_sh_d;
         b_sh_q     <= b_sh_d;
         chk_q      <= chk_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         result_q   <= result_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign o_A        = a_q;
   assign o_B        = b_q;
   assign o_op       = op_q;
   assign o_tx_data  = tx_data_q;
   assign o_tx_start = tx_start_q;
   assign o_busy     = busy_q;
   assign o_err_cnt  = err_cnt_q;

endmodule : uart_alu_frame_ctrl
`default_nettype wire

// File: tb/tb_uart_alu_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_alu_frame_ctrl
// Brief    : Directed self-checking bench for uart_alu_frame_ctrl. The ALU is
//            modelled as an adder; the transmitter acknowledges each byte
//            two cycles after its start pulse. Timeout scenarios are compiled
//            in when FRAME_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_alu_frame_ctrl;

   localparam int N     = 8;
   localparam int ERR_W = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [N-1:0]     i_rx_data = '0;
   logic             i_rx_valid = 1'b0;
   logic             i_tx_done = 1'b0;
   logic [N-1:0]     i_alu_result;
   logic [N-1:0]     o_A, o_B, o_op, o_tx_data;
   logic             o_tx_start, o_busy;
   logic [ERR_W-1:0] o_err_cnt;

   int               checks = 0;
   int               fails = 0;
   int               tx_starts = 0;
   logic [ERR_W-1:0] exp_err = '0;

   uart_alu_frame_ctrl #(
      .N              (N),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (100),
      .ERR_W          (ERR_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_rx_data    (i_rx_data),
      .i_rx_valid   (i_rx_valid),
      .i_tx_done    (i_tx_done),
      .i_alu_result (i_alu_result),
      .o_A          (o_A),
      .o_B          (o_B),
      .o_op         (o_op),
      .o_tx_data    (o_tx_data),
      .o_tx_start   (o_tx_start),
      .o_busy       (o_busy),
      .o_err_cnt    (o_err_cnt)
   );

   always #5 clk = ~clk;

   // ALU model: addition, op code ignored
   assign i_alu_result = o_A + o_B;

   // Count every transmit request
   always @(negedge clk) begin
      if (o_tx_start === 1'b1) tx_starts++;
   end

   task automatic send_byte(input logic [7:0] b);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      @(posedge clk); #1;
      i_rx_valid = 1'b0;
      i_rx_data  = '0;
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] chk);
      send_byte(8'hA5);
      send_byte(op);
      send_byte(a);
      send_byte(b);
      send_byte(chk);
   endtask

   task automatic ack_byte();
      repeat (2) begin @(posedge clk); #1; end
      i_tx_done = 1'b1;
      @(posedge clk); #1;
      i_tx_done = 1'b0;
   endtask

   // Wait (bounded) for a start pulse, take the byte, then acknowledge it
   task automatic collect_byte(output logic [7:0] v, output logic got);
      int n = 0;
      v   = '0;
      got = 1'b0;
      while (!got && n < 20) begin
         if (o_tx_start === 1'b1) begin
            v   = o_tx_data;
            got = 1'b1;
         end else begin
            @(posedge clk); #1;
            n++;
         end
      end
      if (got) ack_byte();
   endtask

   task automatic test_reset();
      checks++; if (o_A !== 8'h00 || o_B !== 8'h00 || o_op !== 8'h00) begin
         fails++; $display("FAIL reset_operands: got A=%h B=%h op=%h required 00", o_A, o_B, o_op); end
      checks++; if (o_tx_start !== 1'b0 || o_tx_data !== 8'h00) begin
         fails++; $display("FAIL reset_tx: got start=%b data=%h required 0/00", o_tx_start, o_tx_data); end
      checks++; if (o_busy !== 1'b0 || o_err_cnt !== 8'h00) begin
         fails++; $display("FAIL reset_status: got busy=%b err=%h required 0/00", o_busy, o_err_cnt); end
   endtask

   task automatic test_valid_frame();
      send_frame(8'h00, 8'h05, 8'h03, 8'h06);
      // CHECK cycle: nothing committed yet
      checks++; if (o_A !== 8'h00 || o_tx_start !== 1'b0 || o_busy !== 1'b1) begin
         fails++; $display("FAIL valid_check_cycle: got A=%h start=%b busy=%b required 00/0/1", o_A, o_tx_start, o_busy); end
      @(posedge clk); #1;
      checks++; if (o_A !== 8'h05 || o_B !== 8'h03 || o_op !== 8'h00 || o_tx_start !== 1'b0) begin
         fails++; $display("FAIL valid_commit: got A=%h B=%h op=%h start=%b required 05/03/00/0", o_A, o_B, o_op, o_tx_start); end
      @(posedge clk); #1;
      checks++; if (o_tx_start !== 1'b1 || o_tx_data !== 8'h00) begin
         fails++; $display("FAIL valid_status_start: got start=%b data=%h required 1/00", o_tx_start, o_tx_data); end
      @(posedge clk); #1;
      checks++; if (o_tx_start !== 1'b0 || o_tx_data !== 8'h00) begin
         fails++; $display("FAIL valid_status_hold: got start=%b data=%h required 0/00", o_tx_start, o_tx_data); end
      i_tx_done = 1'b1; @(posedge clk); #1; i_tx_done = 1'b0;
      checks++; if (o_tx_start !== 1'b1 || o_tx_data !== 8'h08) begin
         fails++; $display("FAIL valid_result_start: got start=%b data=%h required 1/08", o_tx_start, o_tx_data); end
      @(posedge clk); #1;
      checks++; if (o_busy !== 1'b1) begin
         fails++; $display("FAIL valid_busy_wait_res: got %b required 1", o_busy); end
      i_tx_done = 1'b1; @(posedge clk); #1; i_tx_done = 1'b0;
      checks++; if (o_busy !== 1'b0 || tx_starts != 2) begin
         fails++; $display("FAIL valid_done: got busy=%b starts=%0d required 0/2", o_busy, tx_starts); end
   endtask

   task automatic test_bad_checksum();
      logic [7:0] r;
      logic       got;
      send_frame(8'h01, 8'h05, 8'h03, 8'hFF);
      exp_err = exp_err + 8'd1;
      @(posedge clk); #1;
      checks++; if (o_tx_start !== 1'b1 || o_tx_data !== 8'h01) begin
         fails++; $display("FAIL bad_status_latency: got start=%b data=%h required 1/01", o_tx_start, o_tx_data); end
      checks++; if (o_err_cnt !== exp_err) begin
         fails++; $display("FAIL bad_err_cnt: got %h required %h", o_err_cnt, exp_err); end
      ack_byte();
      collect_byte(r, got);
      checks++; if (!got || r !== 8'h00) begin
         fails++; $display("FAIL bad_result: got %h (seen=%b) required 00", r, got); end
      checks++; if (o_A !== 8'h05 || o_B !== 8'h03 || o_op !== 8'h00 || o_busy !== 1'b0) begin
         fails++; $display("FAIL bad_alu_hold: got A=%h B=%h op=%h busy=%b required 05/03/00/0", o_A, o_B, o_op, o_busy); end
   endtask

   task automatic test_garbage_then_frame();
      logic [7:0] st, r;
      logic       g1, g2;
      send_byte(8'h11);
      send_byte(8'h22);
      checks++; if (o_busy !== 1'b0) begin
         fails++; $display("FAIL garbage_ignored: got busy=%b required 0", o_busy); end
      send_frame(8'h00, 8'hA5, 8'h01, 8'hA4);
      collect_byte(st, g1);
      collect_byte(r, g2);
      checks++; if (!g1 || !g2 || st !== 8'h00 || r !== 8'hA6) begin
         fails++; $display("FAIL sync_as_data_resp: got st=%h res=%h required 00/A6", st, r); end
      checks++; if (o_A !== 8'hA5 || o_B !== 8'h01) begin
         fails++; $display("FAIL sync_as_data_ops: got A=%h B=%h required A5/01", o_A, o_B); end
   endtask

   task automatic test_stray_events();
      logic [7:0] r;
      logic       got;
      int         t0;
      t0 = tx_starts;
      send_frame(8'h00, 8'h10, 8'h20, 8'h30);
      repeat (2) begin @(posedge clk); #1; end
      checks++; if (o_tx_start !== 1'b1 || o_tx_data !== 8'h00) begin
         fails++; $display("FAIL stray_status_start: got start=%b data=%h required 1/00", o_tx_start, o_tx_data); end
      @(posedge clk); #1;
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'hFF);
      checks++; if (o_busy !== 1'b1 || o_tx_start !== 1'b0 || o_tx_data !== 8'h00) begin
         fails++; $display("FAIL stray_rx_in_wait: got busy=%b start=%b data=%h required 1/0/00", o_busy, o_tx_start, o_tx_data); end
      i_tx_done = 1'b1; @(posedge clk); #1; i_tx_done = 1'b0;
      collect_byte(r, got);
      checks++; if (!got || r !== 8'h30) begin
         fails++; $display("FAIL stray_result: got %h (seen=%b) required 30", r, got); end
      for (int i = 0; i < 3; i++) begin
         i_tx_done = 1'b1; @(posedge clk); #1; i_tx_done = 1'b0;
         @(posedge clk); #1;
      end
      checks++; if (o_busy !== 1'b0 || (tx_starts - t0) != 2 || o_err_cnt !== exp_err) begin
         fails++; $display("FAIL stray_done_idle: got busy=%b starts=%0d err=%h required 0/2/%h", o_busy, tx_starts - t0, o_err_cnt, exp_err); end
   endtask

   task automatic test_err_saturate();
      logic [7:0] st, r;
      logic       g1, g2;
      while (exp_err != 8'hFF) begin
         send_frame(8'h00, 8'h00, 8'h00, 8'h01);
         collect_byte(st, g1);
         collect_byte(r, g2);
         exp_err = exp_err + 8'd1;
      end
      checks++; if (o_err_cnt !== 8'hFF) begin
         fails++; $display("FAIL sat_reach: got %h required FF", o_err_cnt); end
      send_frame(8'h00, 8'h00, 8'h00, 8'h01);
      collect_byte(st, g1);
      collect_byte(r, g2);
      checks++; if (o_err_cnt !== 8'hFF) begin
         fails++; $display("FAIL sat_hold: got %h required FF", o_err_cnt); end
      checks++; if (!g1 || !g2 || st !== 8'h01 || r !== 8'h00) begin
         fails++; $display("FAIL sat_resp: got st=%h res=%h required 01/00", st, r); end
      checks++; if (o_A !== 8'h10 || o_B !== 8'h20 || o_op !== 8'h00) begin
         fails++; $display("FAIL sat_alu_hold: got A=%h B=%h op=%h required 10/20/00", o_A, o_B, o_op); end
   endtask

   task automatic test_reset_mid_tx();
      logic [7:0] st, r;
      logic       g1, g2;
      send_frame(8'h00, 8'h07, 8'h09, 8'h0E);
      collect_byte(st, g1);
      checks++; if (!g1 || st !== 8'h00 || o_tx_start !== 1'b1 || o_tx_data !== 8'h10) begin
         fails++; $display("FAIL rst_pre_status: got st=%h start=%b data=%h required 00/1/10", st, o_tx_start, o_tx_data); end
      @(posedge clk); #1;
      #2 reset = 1'b0;
      #1;
      exp_err = '0;
      checks++; if (o_A !== 8'h00 || o_B !== 8'h00 || o_op !== 8'h00 || o_tx_data !== 8'h00) begin
         fails++; $display("FAIL rst_async_data: got A=%h B=%h op=%h tx=%h required 00", o_A, o_B, o_op, o_tx_data); end
      checks++; if (o_busy !== 1'b0 || o_tx_start !== 1'b0 || o_err_cnt !== 8'h00) begin
         fails++; $display("FAIL rst_async_ctrl: got busy=%b start=%b err=%h required 0/0/00", o_busy, o_tx_start, o_err_cnt); end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      i_tx_done = 1'b1; @(posedge clk); #1; i_tx_done = 1'b0;
      checks++; if (o_busy !== 1'b0 || o_tx_start !== 1'b0) begin
         fails++; $display("FAIL rst_late_done: got busy=%b start=%b required 0/0", o_busy, o_tx_start); end
      send_frame(8'h02, 8'h03, 8'h04, 8'h05);
      collect_byte(st, g1);
      collect_byte(r, g2);
      checks++; if (!g1 || !g2 || st !== 8'h00 || r !== 8'h07 || o_op !== 8'h02 || o_err_cnt !== 8'h00) begin
         fails++; $display("FAIL rst_next_frame: got st=%h res=%h op=%h err=%h required 00/07/02/00", st, r, o_op, o_err_cnt); end
   endtask

`ifdef FRAME_TIMEOUT_EN
   task automatic test_timeout();
      logic [7:0] st, r;
      logic       g1, g2;
      int         t0;
      t0 = tx_starts;
      send_byte(8'hA5);
      send_byte(8'h00);
      repeat (101) begin @(posedge clk); #1; end
      exp_err = exp_err + 8'd1;
      checks++; if (o_busy !== 1'b0 || o_err_cnt !== exp_err || tx_starts != t0) begin
         fails++; $display("FAIL timeout_gap: got busy=%b err=%h starts=%0d required 0/%h/%0d", o_busy, o_err_cnt, tx_starts, exp_err, t0); end
      // Byte lands on the 100th cycle after OP: the expiry cycle
      send_byte(8'hA5);
      send_byte(8'h00);
      repeat (99) begin @(posedge clk); #1; end
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      collect_byte(st, g1);
      collect_byte(r, g2);
      checks++; if (!g1 || !g2 || st !== 8'h00 || r !== 8'h03 || o_err_cnt !== exp_err) begin
         fails++; $display("FAIL timeout_edge_byte: got st=%h res=%h err=%h required 00/03/%h", st, r, o_err_cnt, exp_err); end
   endtask
`endif

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      test_valid_frame();
      test_bad_checksum();
      test_garbage_then_frame();
      test_stray_events();
      test_err_saturate();
      test_reset_mid_tx();
`ifdef FRAME_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule : tb_uart_alu_frame_ctrl
`default_nettype wire

// File: doc/uart_alu_frame_ctrl.md
Name: uart_alu_frame_ctrl

Overview:
Framed command sequencer between the UART receiver/transmitter pair and the combinational ALU. It parses a 5-byte command frame: SYNC, OP, A, B, CHK. On a valid frame it commits operands to the ALU, captures the result, and returns a 2-byte response frame (STATUS, RESULT) through the transmitter handshake. Its role is the byte-level interface block, adding integrity checking, error reporting and a busy indication.

Parameters:
N, 8, data/byte width of UART bytes, ALU operands and result
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 1000000, max clk cycles between consecutive frame bytes (only with FRAME_TIMEOUT_EN)
ERR_W, 8, width of saturating error counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
i_rx_data  in  N  byte from uart_rx
i_rx_valid  in  1  one-cycle pulse, i_rx_data valid
i_tx_done  in  1  one-cycle pulse, transmitter finished current byte
i_alu_result  in  N  combinational ALU output
o_A  out  N  ALU operand A
o_B  out  N  ALU operand B
o_op  out  N  ALU operation code
o_tx_data  out  N  byte to transmit
o_tx_start  out  1  one-cycle pulse requesting transmission
o_busy  out  1  high in any state except IDLE
o_err_cnt  out  ERR_W  saturating count of checksum errors and timeouts

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; shadow regs, timeout counter and o_err_cnt cleared.
- States and transitions:
  - IDLE: on rx_valid && data==SYNC_BYTE -> GET_OP. Other bytes are ignored.
  - GET_OP, GET_A, GET_B: on rx_valid, latch into shadow op/a/b and advance.
  - GET_CHK: on rx_valid -> CHECK.
  - CHECK (1 cycle):
    - If CHK == op^a^b: load o_op/o_A/o_B from shadows -> EXEC.
    - Else: status=8'h01, result=0, o_err_cnt+1 -> SEND_ST.
  - EXEC (1 cycle): ALU output has settled from the committed operands. Capture i_alu_result, status=8'h00 -> SEND_ST.
  - SEND_ST: pulse o_tx_start for one cycle with o_tx_data=status -> WAIT_ST.
  - WAIT_ST: on i_tx_done -> SEND_RES.
  - SEND_RES: pulse o_tx_start with o_tx_data=result -> WAIT_RES.
  - WAIT_RES: on i_tx_done -> IDLE.
- o_tx_data holds stable from the start pulse until the matching tx_done.
- o_tx_start is never asserted while a byte is in flight.
- o_A/o_B/o_op change only in CHECK on a passing checksum; otherwise they hold their last committed values. A failed frame never disturbs the ALU.
- A SYNC_BYTE value received mid-frame is treated as data; there is no resync.
- rx_valid in CHECK, EXEC, SEND_* or WAIT_* states is dropped silently and not counted.
- i_tx_done outside the WAIT_* states is ignored.
- o_err_cnt saturates at all-ones and never wraps.
- Latency: last CHK byte valid -> first o_tx_start = 3 cycles (CHECK, EXEC, SEND_ST) on a pass, 2 cycles on a fail.
- An async reset mid-frame or mid-transmission aborts immediately. The transmitter may still finish its byte; the resulting tx_done is ignored in IDLE.

Optional Feature:
FRAME_TIMEOUT_EN
- Defined:
  - In GET_OP..GET_CHK a cycle counter restarts on each accepted byte.
  - When it reaches TIMEOUT_CYCLES without rx_valid, go to IDLE, increment o_err_cnt, and send no response.
  - rx_valid arriving on the same cycle as expiry wins: the byte is accepted.
- Undefined: no counter is built, and the FSM waits indefinitely for each byte.

Decomposition:
- Shared package holds:
  - the state enum;
  - status codes ST_OK=8'h00 and ST_CHK_ERR=8'h01;
  - the SYNC_BYTE default;
  - frame length constants.
- One natural sub-module: frame_timeout_ctr, a loadable cycle counter with an expire pulse, instantiated only under FRAME_TIMEOUT_EN.

Test Plan:
- Valid frame A5,op=00,A=05,B=03,CHK=06 with ALU modelled as add -> o_A=05, o_B=03 committed in CHECK. Transmitted bytes are 00 then 08. o_busy falls after the second tx_done.
- Bad checksum A5,01,05,03,FF -> tx bytes 01 then 00. o_A/o_B/o_op are unchanged from the previous frame, and o_err_cnt increments by 1.
- Garbage 11,22 then a valid frame -> leading bytes ignored in IDLE and the frame is processed normally. A5 used as operand A is accepted as data.
- rx_valid pulses during WAIT_ST and stray tx_done pulses in IDLE -> no state change, no extra o_tx_start, o_err_cnt unchanged.
- Force o_err_cnt to FF and send a bad frame -> stays FF. Reset asserted asynchronously in WAIT_RES -> all outputs 0 immediately and the next frame works.
- With FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=100:
  - a 101-cycle gap after OP -> IDLE, o_err_cnt+1, no tx_start;
  - a byte on exactly the expiry cycle -> accepted.
